or_irq_ctrl: RTL and testbench
==============================

OR_IRQ_CTRL -- requirements
Module: or_irq_ctrl

Interface
REQ-001 Parameter CNT_WIDTH, default 16, width of the event counter.
REQ-002 Parameter TS_WIDTH, default 32, width of the free-running timestamp counter and the captured timestamp.
REQ-003 Parameter HOLDOFF, default 4, number of re-arm holdoff cycles after ack; range 0..255.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 din  input  1  registered reduction-OR flag from the upstream pipe_or stage; a level input.
REQ-007 en  input  1  arm enable; gates event counting and interrupt arming.
REQ-008 ack  input  1  interrupt acknowledge, single-cycle pulse or level.
REQ-009 clr_cnt  input  1  synchronous clear of evt_cnt and lost.
REQ-010 irq  output  1  interrupt request, registered.
REQ-011 evt_cnt  output  CNT_WIDTH  saturating count of din rising edges seen with en=1.
REQ-012 ts  output  TS_WIDTH  timestamp captured when irq arms.
REQ-013 lost  output  1  sticky flag: an enabled rising edge occurred while irq was pending or in holdoff.

Function
REQ-014 din_q holds din sampled at the previous edge; rise = din AND NOT din_q, evaluated at each edge.
REQ-015 tcnt is a free-running TS_WIDTH counter, incremented every cycle, wrapping from all-ones to 0.
REQ-016 evt_cnt increments by 1 on an edge with rise=1 and en=1; it holds at all-ones (no wrap).
REQ-017 clr_cnt=1 forces evt_cnt to 0 and lost to 0 at that edge and overrides a simultaneous increment or set.
REQ-018 FSM states: IDLE, PENDING, HOLD. irq=1 only in PENDING.
REQ-019 IDLE -> PENDING on an edge with rise=1 and en=1; ts loads the current tcnt (pre-increment value) at that same edge.
REQ-020 irq asserts on the edge at which din is first sampled high after a low sample, with en=1 (zero extra cycles beyond that sample).
REQ-021 PENDING -> HOLD on ack=1 with HOLDOFF>0, loading the holdoff counter with HOLDOFF; PENDING -> IDLE on ack=1 with HOLDOFF=0.
REQ-022 HOLD decrements the holdoff counter each cycle and enters IDLE on the edge where the counter reaches 1, giving exactly HOLDOFF cycles in HOLD.
REQ-023 In PENDING and HOLD, an edge with rise=1 and en=1 increments evt_cnt, sets lost, and leaves ts unchanged.
REQ-024 ack in IDLE or HOLD is ignored; en=0 in PENDING does not clear irq, and irq is held until ack.
REQ-025 A din held high produces exactly one rise; a new event requires din to be sampled low first.
REQ-026 In a cycle where ack=1 and rise=1 both occur in PENDING, the ack takes effect (-> HOLD/IDLE) and the rise counts as lost.

Reset
REQ-027 rst_n=0 asynchronously forces: state IDLE, irq=0, evt_cnt=0, ts=0, lost=0, tcnt=0, din_q=0, holdoff counter 0.
REQ-028 Reset asserted mid-PENDING or mid-HOLD aborts immediately; after release the block is IDLE, and a din already high at release counts as one rise on the first edge.

Verification
REQ-029 Basic: rst_n released, en=1, din 0->1 sampled at edge 5 (tcnt=4) -> irq=1 after edge 5, ts=4, evt_cnt=1, lost=0.
REQ-030 Holdoff: HOLDOFF=4, ack pulse in PENDING -> irq=0 next edge, 4 cycles in HOLD; a din pulse within HOLD -> evt_cnt+1, lost=1, irq stays 0; a pulse after HOLD -> irq=1 with a new ts.
REQ-031 Saturation: CNT_WIDTH=4, 20 enabled din pulses -> evt_cnt=15 stays 15; clr_cnt -> evt_cnt=0, lost=0.
REQ-032 Gating: en=0, 3 din pulses -> irq=0, evt_cnt=0; din held high 10 cycles with en=1 -> exactly one count.
REQ-033 Simultaneous: ack and rise on the same edge in PENDING -> state HOLD, lost=1, ts unchanged; clr_cnt together with rise -> evt_cnt=0.
REQ-034 Async reset: rst_n low between edges while irq=1 -> irq, evt_cnt, ts drop to 0 before the next edge; chain with pipe_or (WIDTH=100, latency 3) -> irq rises 4 edges after a bit of a is set.

Source files
------------

// File: rtl/or_irq_ctrl.sv
// ---------------------------------------------------------------------------
// or_irq_ctrl
//   Turns the registered reduction-OR flag of an upstream pipe_or stage into
//   an acknowledged interrupt. Rising edges of din (with en=1) are counted
//   and saturate at all-ones. The first edge arms irq and captures the
//   free-running timestamp. After ack, a programmable holdoff window runs.
//   Edges that arrive while irq is pending or in holdoff set the sticky
//   lost flag.
//
// State table
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_IDLE    | armed; the next enabled rise raises irq and captures ts
//   ST_PENDING | irq asserted, waiting for ack
//   ST_HOLD    | re-arm holdoff, HOLDOFF cycles long
//
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   din      in   level flag from pipe_or
//   en       in   arm enable; gates counting and arming
//   ack      in   interrupt acknowledge; used only in ST_PENDING
//   clr_cnt  in   synchronous clear of evt_cnt and lost
//   irq      out  interrupt request (registered)
//   evt_cnt  out  saturating count of enabled din rises
//   ts       out  tcnt value captured when irq arms
//   lost     out  sticky: an enabled rise arrived while pending or in holdoff
// ---------------------------------------------------------------------------
module or_irq_ctrl #(
  parameter int CNT_WIDTH = 16,
  parameter int TS_WIDTH  = 32,
  parameter int HOLDOFF   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din,
  input  logic                 en,
  input  logic                 ack,
  input  logic                 clr_cnt,
  output logic                 irq,
  output logic [CNT_WIDTH-1:0] evt_cnt,
  output logic [TS_WIDTH-1:0]  ts,
  output logic                 lost
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF);

  state_t                state_q, state_d;
  logic [7:0]            hold_q, hold_d;
  logic                  din_q;
  logic [TS_WIDTH-1:0]   tcnt_q;
  logic [TS_WIDTH-1:0]   ts_q, ts_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  lost_q, lost_d;
  logic                  irq_q;
  logic                  rise_en;

  assign rise_en = din & ~din_q & en;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    ts_d    = ts_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rise_en) begin
          state_d = ST_PENDING;
          ts_d    = tcnt_q;
        end
      end
      ST_PENDING: begin
        // ack wins over a coincident rise; that rise is accounted as lost
        if (ack) begin
          if (HOLD_LOAD == 8'd0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
            hold_d  = HOLD_LOAD;
          end
        end
      end
      ST_HOLD: begin
        // leaving on the count of 1 yields exactly HOLDOFF cycles here
        if (hold_q <= 8'd1) begin
          state_d = ST_IDLE;
          hold_d  = 8'd0;
        end else begin
          hold_d  = hold_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = 8'd0;
      end
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    lost_d = lost_q;
    if (rise_en) begin
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
      if (state_q != ST_IDLE) begin
        lost_d = 1'b1;
      end
    end
    if (clr_cnt) begin
      cnt_d  = '0;
      lost_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hold_q  <= 8'd0;
      din_q   <= 1'b0;
      tcnt_q  <= '0;
      ts_q    <= '0;
      cnt_q   <= '0;
      lost_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      din_q   <= din;
      tcnt_q  <= tcnt_q + TS_WIDTH'(1);
      ts_q    <= ts_d;
      cnt_q   <= cnt_d;
      lost_q  <= lost_d;
      irq_q   <= (state_d == ST_PENDING);
    end
  end

  assign irq     = irq_q;
  assign evt_cnt = cnt_q;
  assign ts      = ts_q;
  assign lost    = lost_q;

endmodule

// File: tb/tb_or_irq_ctrl.sv
module tb_or_irq_ctrl;

  localparam int CW   = 4;
  localparam int TW   = 32;
  localparam int HOLD = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          din;
  logic          en;
  logic          ack;
  logic          clr_cnt;
  logic          irq;
  logic [CW-1:0] evt_cnt;
  logic [TW-1:0] ts;
  logic          lost;

  int checks = 0;
  int errors = 0;

  // Event-level reference: the controller is "busy" while an irq is
  // outstanding or until edge number busy_until (ack edge + HOLD).
  bit      m_din_prev;
  bit      m_pending;
  int      m_busy_until;
  int      m_edge;
  int      m_cnt;
  int      m_ts;
  bit      m_lost;

  or_irq_ctrl #(.CNT_WIDTH(CW), .TS_WIDTH(TW), .HOLDOFF(HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .en      (en),
    .ack     (ack),
    .clr_cnt (clr_cnt),
    .irq     (irq),
    .evt_cnt (evt_cnt),
    .ts      (ts),
    .lost    (lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_din_prev   = 1'b0;
    m_pending    = 1'b0;
    m_busy_until = 0;
    m_edge       = 0;
    m_cnt        = 0;
    m_ts         = 0;
    m_lost       = 1'b0;
  endtask

  task automatic model_edge(input bit d, input bit e, input bit a, input bit c);
    bit rise;
    bit was_pending;
    rise        = d && !m_din_prev;
    m_din_prev  = d;
    m_edge++;
    was_pending = m_pending;
    if (rise && e) begin
      if (m_cnt < CMAX) m_cnt++;
      if (!m_pending && m_edge > m_busy_until) begin
        m_pending = 1'b1;
        m_ts      = m_edge - 1;
      end else begin
        m_lost = 1'b1;
      end
    end
    if (was_pending && a) begin
      m_pending    = 1'b0;
      m_busy_until = m_edge + HOLD;
    end
    if (c) begin
      m_cnt  = 0;
      m_lost = 1'b0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".irq"},  32'(irq),     32'(m_pending));
    check({tag, ".cnt"},  32'(evt_cnt), 32'(m_cnt));
    check({tag, ".ts"},   ts,           32'(m_ts));
    check({tag, ".lost"}, 32'(lost),    32'(m_lost));
  endtask

  task automatic step(input string tag, input logic d, input logic e, input logic a, input logic c);
    din = d; en = e; ack = a; clr_cnt = c;
    @(posedge clk);
    model_edge(d, e, a, c);
    #1;
    compare_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; din = 1'b0; en = 1'b1; ack = 1'b0; clr_cnt = 1'b0;
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic arm: din sampled high at edge 5, tcnt=4 there
    for (int i = 0; i < 4; i++) step("basic_low", 1'b0, 1'b1, 1'b0, 1'b0);
    step("basic_rise", 1'b1, 1'b1, 1'b0, 1'b0);
    check("basic_irq", 32'(irq), 32'd1);
    check("basic_ts",  ts,       32'd4);
    check("basic_cnt", 32'(evt_cnt), 32'd1);

    // Holdoff: ack, pulse inside the window, pulse after it
    step("hold_ack", 1'b1, 1'b1, 1'b1, 1'b0);
    check("hold_irq_drop", 32'(irq), 32'd0);
    step("hold_w1", 1'b0, 1'b1, 1'b0, 1'b0);
    step("hold_w2", 1'b1, 1'b1, 1'b0, 1'b0);
    check("hold_lost", 32'(lost), 32'd1);
    check("hold_irq_stays", 32'(irq), 32'd0);
    step("hold_w3", 1'b0, 1'b1, 1'b0, 1'b0);
    step("hold_w4", 1'b0, 1'b1, 1'b0, 1'b0);
    step("hold_after", 1'b1, 1'b1, 1'b0, 1'b0);
    check("hold_rearm", 32'(irq), 32'd1);

    // ack coincident with rise: rise is lost, ts unchanged
    step("sim_low", 1'b0, 1'b1, 1'b0, 1'b1);
    step("sim_ack_rise", 1'b1, 1'b1, 1'b1, 1'b0);
    check("sim_lost", 32'(lost), 32'd1);
    check("sim_irq",  32'(irq),  32'd0);
    // clr together with rise wins
    for (int i = 0; i < 6; i++) step("sim_wait", 1'b0, 1'b1, 1'b0, 1'b0);
    step("clr_rise", 1'b1, 1'b1, 1'b0, 1'b1);
    check("clr_rise_cnt", 32'(evt_cnt), 32'd0);
    step("clr_ack", 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step("clr_wait", 1'b0, 1'b1, 1'b0, 1'b0);

    // Gating: en=0 pulses do nothing; a held-high din counts once
    for (int i = 0; i < 3; i++) begin
      step("gate_hi", 1'b1, 1'b0, 1'b0, 1'b0);
      step("gate_lo", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("gate_irq", 32'(irq), 32'd0);
    step("gate_clr", 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step("held_hi", 1'b1, 1'b1, 1'b0, 1'b0);
    check("held_once", 32'(evt_cnt), 32'd1);
    step("held_ack", 1'b0, 1'b1, 1'b1, 1'b0);

    // Saturation at 15, then clear
    for (int i = 0; i < 20; i++) begin
      step("sat_hi", 1'b1, 1'b1, 1'b0, 1'b0);
      step("sat_lo", 1'b0, 1'b1, 1'b0, 1'b0);
    end
    check("sat_cnt", 32'(evt_cnt), 32'd15);
    step("sat_clr", 1'b0, 1'b1, 1'b0, 1'b1);
    check("sat_clr_cnt",  32'(evt_cnt), 32'd0);
    check("sat_clr_lost", 32'(lost),    32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step("rand",
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 31) == 0));
    end

    // Async reset while irq pending, din high at release
    step("ar_ack", 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step("ar_wait", 1'b0, 1'b1, 1'b0, 1'b0);
    step("ar_arm", 1'b1, 1'b1, 1'b0, 1'b0);
    check("ar_pending", 32'(irq), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("ar_irq", 32'(irq),     32'd0);
    check("ar_cnt", 32'(evt_cnt), 32'd0);
    check("ar_ts",  ts,           32'd0);
    model_reset();
    #2;
    rst_n = 1'b1;
    step("ar_first_edge", 1'b1, 1'b1, 1'b0, 1'b0);
    check("ar_rise_counted", 32'(evt_cnt), 32'd1);
    check("ar_ts_zero", ts, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
